// File: rtl/lvl_queue_dispatcher_if.sv
// rtl/lvl_queue_dispatcher_if.sv - request push and car status bundle for the floor-queue dispatcher
interface lvl_queue_dispatcher_if;
    logic       add_new_lvl;
    logic [1:0] pressed_lvl;
    logic [7:0] queue;
    logic [2:0] tail;
    logic [1:0] cur_lvl;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       arrived;

    modport master (
        output add_new_lvl, pressed_lvl,
        input  queue, tail, cur_lvl, moving_up, moving_down, door_open, arrived
    );

    modport slave (
        input  add_new_lvl, pressed_lvl,
        output queue, tail, cur_lvl, moving_up, moving_down, door_open, arrived
    );
endinterface

// File: rtl/lvl_queue_dispatcher.sv
// rtl/lvl_queue_dispatcher.sv - floor-request queue owner that moves the car to each head entry and pops it
module lvl_queue_dispatcher #(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lvl_queue_dispatcher_if.slave  bus
);
    localparam int CMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    queue_q, queue_d;
    logic [2:0]    tail_q, tail_d;
    logic [1:0]    cur_q, cur_d;
    logic          up_q, up_d, down_q, down_d, door_q, door_d, arr_q, arr_d;

    logic       pop;
    logic [1:0] head;
    logic [1:0] next_lvl;
    logic [2:0] tail_pop;

    assign head     = queue_q[1:0];
    assign pop      = (state_q == S_DOOR) && (cnt_q == '0);
    assign tail_pop = tail_q - 3'd1;

    // A push landing on the pop cycle fills the slot the shift just freed.
    always_comb begin
        queue_d = queue_q;
        tail_d  = tail_q;
        if (pop) begin
            queue_d = {2'b00, queue_q[7:2]};
            tail_d  = tail_pop;
            if (bus.add_new_lvl) begin
                queue_d[{tail_pop[1:0], 1'b0} +: 2] = bus.pressed_lvl;
                tail_d = tail_q;
            end
        end else if (bus.add_new_lvl && (tail_q != 3'd4)) begin
            queue_d[{tail_q[1:0], 1'b0} +: 2] = bus.pressed_lvl;
            tail_d = tail_q + 3'd1;
        end
    end

    always_comb begin
        next_lvl = cur_q;
        if (dir_q && (cur_q != 2'd3)) begin
            next_lvl = cur_q + 2'd1;
        end else if (!dir_q && (cur_q != 2'd0)) begin
            next_lvl = cur_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (tail_q != 3'd0) begin
                    if (head == cur_q) begin
                        state_d = S_DOOR;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        state_d = S_MOVE;
                        dir_d   = (head > cur_q);
                        cnt_d   = MOVE_LOAD;
                    end
                end
            end
            S_MOVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cur_d = next_lvl;
                    if (next_lvl == head) begin
                        state_d = S_DOOR;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        cnt_d = MOVE_LOAD;
                    end
                end
            end
            S_DOOR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status flags decode the next state so they line up with it as flops.
        up_d   = (state_d == S_MOVE) && dir_d;
        down_d = (state_d == S_MOVE) && !dir_d;
        door_d = (state_d == S_DOOR);
        arr_d  = (state_d == S_DOOR) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            queue_q <= 8'h00;
            tail_q  <= 3'd0;
            cur_q   <= 2'd0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            door_q  <= 1'b0;
            arr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            queue_q <= queue_d;
            tail_q  <= tail_d;
            cur_q   <= cur_d;
            up_q    <= up_d;
            down_q  <= down_d;
            door_q  <= door_d;
            arr_q   <= arr_d;
        end
    end

    assign bus.queue       = queue_q;
    assign bus.tail        = tail_q;
    assign bus.cur_lvl     = cur_q;
    assign bus.moving_up   = up_q;
    assign bus.moving_down = down_q;
    assign bus.door_open   = door_q;
    assign bus.arrived     = arr_q;
endmodule
